// File: rtl/regfile_serial_reader.sv
// Reads one byte from a synchronous-read register file and sends it as a
// serial frame: start bit (0), 8 data bits MSB first, stop bit (1).
module regfile_serial_reader #(
    parameter int ADDR_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_rd_en,
    input  logic [7:0]        rf_rdata,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    // Terminal count of the per-bit counter; at CLKS_PER_BIT=1 this is 0,
    // so each bit leaves its state on the first cycle without underflow.
    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 255) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be in 1..255");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic              ser_out_q, ser_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        clk_cnt_q, clk_cnt_d;

    logic              bit_last;
    assign bit_last = (clk_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        rf_addr_d  = rf_addr_q;
        rf_rd_en_d = 1'b0;
        ser_out_d  = ser_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        clk_cnt_d  = clk_cnt_q;

        case (state_q)
            S_IDLE: begin
                ser_out_d = 1'b1;
                busy_d    = 1'b0;
                if (rd_req) begin
                    rf_addr_d  = rd_addr;
                    rf_rd_en_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Read data is valid exactly one cycle after the read enable.
                shift_d   = rf_rdata;
                ser_out_d = 1'b0;
                clk_cnt_d = 8'd0;
                state_d   = S_START;
            end
            S_START: begin
                if (bit_last) begin
                    ser_out_d = shift_q[7];
                    bit_cnt_d = 3'd0;
                    clk_cnt_d = 8'd0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    clk_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        ser_out_d = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        ser_out_d = shift_q[6];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    clk_cnt_d = 8'd0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ser_out_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rf_addr_q  <= '0;
            rf_rd_en_q <= 1'b0;
            ser_out_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            clk_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            rf_addr_q  <= rf_addr_d;
            rf_rd_en_q <= rf_rd_en_d;
            ser_out_q  <= ser_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            clk_cnt_q  <= clk_cnt_d;
        end
    end

    assign rf_addr  = rf_addr_q;
    assign rf_rd_en = rf_rd_en_q;
    assign ser_out  = ser_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
